texture_cache_2way: RTL and testbench

//  Parametrised successor to the GPU direct-mapped texture cache: 2-way set-associative, NPORTS lookup ports, per-set LRU.

---
 rtl/texture_cache_2way.sv | 153 +++++++++++++++
 tb/tb_texture_cache_2way.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_cache_2way.sv
// 2-way set-associative texture cache with NPORTS lookup ports that fills itself from snooped VRAM writes.
// The lookup result appears one cycle after the request. There is no backpressure: every port accepts a lookup every cycle.
module texture_cache_2way #(
  parameter int NPORTS   = 2,
  parameter int SET_BITS = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clearCache,
  input  logic                   i_textureFormatTrueColor,
  input  logic                   i_write,
  input  logic [16:0]            i_adressIn,
  input  logic [63:0]            i_dataIn,
  input  logic [NPORTS-1:0]      i_requLookup,
  input  logic [19*NPORTS-1:0]   i_adressLook,
  output logic [16*NPORTS-1:0]   o_dataOut,
  output logic [NPORTS-1:0]      o_isHit,
  output logic [NPORTS-1:0]      o_isMiss
);
  localparam int TAG_W = 17 - SET_BITS;
  localparam int SETS  = 1 << SET_BITS;

  logic [TAG_W-1:0] tag0_mem  [SETS];
  logic [TAG_W-1:0] tag1_mem  [SETS];
  logic [63:0]      data0_mem [SETS];
  logic [63:0]      data1_mem [SETS];

  logic [SETS-1:0] valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;

  logic [NPORTS-1:0][SET_BITS-1:0] p_set_q, p_set_d;
  logic [NPORTS-1:0][TAG_W-1:0]    p_tag_q, p_tag_d;
  logic [NPORTS-1:0][1:0]          p_tex_q, p_tex_d;
  logic [NPORTS-1:0]               p_req_q, p_req_d, sticky_q, sticky_d;

  logic [NPORTS-1:0][16:0] look_s;
  logic [NPORTS-1:0]       hit0, hit1, hit, hit_way;
  logic [NPORTS-1:0][63:0] hit_line;

  logic [16:0]         wr_s;
  logic [SET_BITS-1:0] wr_set;
  logic [TAG_W-1:0]    wr_tag;
  logic                wr_m0, wr_m1, wr_way, wr_en;

  // Spreads neighbouring texels across sets so a 2D footprint rarely thrashes one set.
  function automatic logic [16:0] swizzle(input logic [16:0] w, input logic tc);
    if (tc) return {w[16:13], w[7:3], w[12:8], w[2:0]};
    return {w[16:14], w[7:2], w[13:8], w[1:0]};
  endfunction

  always_comb begin
    look_s  = '0;
    p_set_d = p_set_q;
    p_tag_d = p_tag_q;
    p_tex_d = p_tex_q;
    for (int p = 0; p < NPORTS; p++) begin
      look_s[p]  = swizzle(i_adressLook[19*p+2 +: 17], i_textureFormatTrueColor);
      p_set_d[p] = look_s[p][SET_BITS-1:0];
      p_tag_d[p] = look_s[p][16:SET_BITS];
      p_tex_d[p] = i_adressLook[19*p +: 2];
    end
    p_req_d = i_requLookup;
  end

  always_comb begin
    hit0      = '0;
    hit1      = '0;
    hit       = '0;
    hit_way   = '0;
    hit_line  = '0;
    o_dataOut = '0;
    o_isHit   = '0;
    o_isMiss  = '0;
    sticky_d  = sticky_q;
    for (int p = 0; p < NPORTS; p++) begin
      hit0[p]     = valid0_q[p_set_q[p]] && (tag0_mem[p_set_q[p]] == p_tag_q[p]);
      hit1[p]     = valid1_q[p_set_q[p]] && (tag1_mem[p_set_q[p]] == p_tag_q[p]);
      hit[p]      = hit0[p] | hit1[p];
      hit_way[p]  = !hit0[p];
      hit_line[p] = hit0[p] ? data0_mem[p_set_q[p]] : data1_mem[p_set_q[p]];
      o_dataOut[16*p +: 16] = hit_line[p][16*p_tex_q[p] +: 16];
      o_isHit[p]  = hit[p] & p_req_q[p];
      o_isMiss[p] = (!hit[p] & p_req_q[p]) | (sticky_q[p] & !hit[p]);
      if (o_isHit[p])       sticky_d[p] = 1'b0;
      else if (o_isMiss[p]) sticky_d[p] = 1'b1;
    end
  end

  always_comb begin
    wr_s   = swizzle(i_adressIn, i_textureFormatTrueColor);
    wr_set = wr_s[SET_BITS-1:0];
    wr_tag = wr_s[16:SET_BITS];
    wr_m0  = valid0_q[wr_set] && (tag0_mem[wr_set] == wr_tag);
    wr_m1  = valid1_q[wr_set] && (tag1_mem[wr_set] == wr_tag);
    if (wr_m0)                  wr_way = 1'b0;
    else if (wr_m1)             wr_way = 1'b1;
    else if (!valid0_q[wr_set]) wr_way = 1'b0;
    else if (!valid1_q[wr_set]) wr_way = 1'b1;
    else                        wr_way = lru_q[wr_set];
    wr_en = i_write & !i_clearCache;

    valid0_d = valid0_q;
    valid1_d = valid1_q;
    lru_d    = lru_q;
    // Descending so the lowest port's hit is the one that sticks; a write then overrides both.
    for (int p = NPORTS-1; p >= 0; p--) begin
      if (o_isHit[p]) lru_d[p_set_q[p]] = !hit_way[p];
    end
    if (wr_en) begin
      if (wr_way) valid1_d[wr_set] = 1'b1;
      else        valid0_d[wr_set] = 1'b1;
      lru_d[wr_set] = !wr_way;
    end
    if (i_clearCache) begin
      valid0_d = '0;
      valid1_d = '0;
      lru_d    = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
      p_req_q  <= '0;
      sticky_q <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
      p_req_q  <= p_req_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge i_clk) begin
    p_set_q <= p_set_d;
    p_tag_q <= p_tag_d;
    p_tex_q <= p_tex_d;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      if (wr_way) begin
        tag1_mem[wr_set]  <= wr_tag;
        data1_mem[wr_set] <= i_dataIn;
      end else begin
        tag0_mem[wr_set]  <= wr_tag;
        data0_mem[wr_set] <= i_dataIn;
      end
    end
  end
endmodule

// File: tb/tb_texture_cache_2way.sv
// Bench for texture_cache_2way: directed scenarios plus a randomized run.
// The randomized run is checked against a per-set two-slot reference model.
module tb_texture_cache_2way;
  localparam int NP = 2;
  localparam int SB = 7;
  localparam int NS = 1 << SB;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_clearCache;
  logic             i_textureFormatTrueColor;
  logic             i_write;
  logic [16:0]      i_adressIn;
  logic [63:0]      i_dataIn;
  logic [NP-1:0]    i_requLookup;
  logic [19*NP-1:0] i_adressLook;
  logic [16*NP-1:0] o_dataOut;
  logic [NP-1:0]    o_isHit;
  logic [NP-1:0]    o_isMiss;

  texture_cache_2way #(.NPORTS(NP), .SET_BITS(SB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clearCache(i_clearCache),
    .i_textureFormatTrueColor(i_textureFormatTrueColor),
    .i_write(i_write), .i_adressIn(i_adressIn), .i_dataIn(i_dataIn),
    .i_requLookup(i_requLookup), .i_adressLook(i_adressLook),
    .o_dataOut(o_dataOut), .o_isHit(o_isHit), .o_isMiss(o_isMiss)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each set holds two slots keyed by the full swizzled address.
  bit          m_valid [2][NS];
  logic [16:0] m_key   [2][NS];
  logic [63:0] m_data  [2][NS];
  bit          m_lru   [NS];
  bit          m_sticky[NP];
  bit          e_req   [NP];
  bit          e_hit   [NP];
  int          e_way   [NP];
  int          e_set   [NP];
  logic [15:0] e_dat   [NP];

  function automatic logic [16:0] swz(input logic [16:0] w, input logic tc);
    if (tc) return {w[16:13], w[7:3], w[12:8], w[2:0]};
    return {w[16:14], w[7:2], w[13:8], w[1:0]};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[0][s] = 1'b0;
      m_valid[1][s] = 1'b0;
      m_lru[s] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      m_sticky[p] = 1'b0;
      e_req[p] = 1'b0;
      e_hit[p] = 1'b0;
      e_way[p] = 0;
      e_set[p] = 0;
      e_dat[p] = '0;
    end
  endtask

  task automatic model_step();
    logic [16:0] s;
    int st, way, tex;
    if (i_rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (e_req[p] && e_hit[p]) m_sticky[p] = 1'b0;
      else if (!e_hit[p] && (e_req[p] || m_sticky[p])) m_sticky[p] = 1'b1;
    end
    for (int p = NP-1; p >= 0; p--)
      if (e_req[p] && e_hit[p]) m_lru[e_set[p]] = (e_way[p] == 0);
    if (i_clearCache) begin
      for (int k = 0; k < NS; k++) begin
        m_valid[0][k] = 1'b0;
        m_valid[1][k] = 1'b0;
        m_lru[k] = 1'b0;
      end
    end else if (i_write) begin
      s = swz(i_adressIn, i_textureFormatTrueColor);
      st = int'(s) % NS;
      way = -1;
      for (int w = 0; w < 2; w++)
        if (way < 0 && m_valid[w][st] && m_key[w][st] == s) way = w;
      if (way < 0) way = !m_valid[0][st] ? 0 : (!m_valid[1][st] ? 1 : int'(m_lru[st]));
      m_valid[way][st] = 1'b1;
      m_key[way][st] = s;
      m_data[way][st] = i_dataIn;
      m_lru[st] = (way == 0);
    end
    for (int p = 0; p < NP; p++) begin
      s = swz(i_adressLook[19*p+2 +: 17], i_textureFormatTrueColor);
      st = int'(s) % NS;
      tex = int'(i_adressLook[19*p +: 2]);
      e_req[p] = i_requLookup[p];
      e_set[p] = st;
      e_hit[p] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        if (!e_hit[p] && m_valid[w][st] && m_key[w][st] == s) begin
          e_hit[p] = 1'b1;
          e_way[p] = w;
          e_dat[p] = m_data[w][st][16*tex +: 16];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    i_write = 1'b0;
    i_clearCache = 1'b0;
    i_requLookup = '0;
  endtask

  task automatic look(input int p, input logic [18:0] a);
    i_requLookup[p] = 1'b1;
    i_adressLook[19*p +: 19] = a;
  endtask

  task automatic wr(input logic [16:0] w, input logic [63:0] d);
    i_write = 1'b1;
    i_adressIn = w;
    i_dataIn = d;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_reset();
    idle();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b1;
    model_reset();
    #1;
    checks++; if (o_isHit !== 2'b00) begin errors++; $display("FAIL reset_hit: got %b expected 00", o_isHit); end
    checks++; if (o_isMiss !== 2'b00) begin errors++; $display("FAIL reset_miss: got %b expected 00", o_isMiss); end
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_basic_hit();
    i_textureFormatTrueColor = 1'b1;
    do_reset();
    wr(17'h00010, 64'h4444_3333_2222_1111);
    look(0, 19'h00042);
    tick();
    checks++; if (o_isHit[0] !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b expected 1", o_isHit[0]); end
    checks++; if (o_dataOut[15:0] !== 16'h3333) begin errors++; $display("FAIL basic_data: got %h expected 3333", o_dataOut[15:0]); end
    checks++; if (o_isMiss[0] !== 1'b0) begin errors++; $display("FAIL basic_miss: got %b expected 0", o_isMiss[0]); end
    idle();
  endtask

  task automatic test_sticky_miss();
    do_reset();
    look(1, 19'h00100);
    tick();
    checks++; if (o_isMiss[1] !== 1'b1) begin errors++; $display("FAIL sticky_spike: got %b expected 1", o_isMiss[1]); end
    checks++; if (o_isHit[1] !== 1'b0) begin errors++; $display("FAIL sticky_nohit: got %b expected 0", o_isHit[1]); end
    idle();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (o_isMiss[1] !== 1'b1) begin errors++; $display("FAIL sticky_hold%0d: got %b expected 1", c, o_isMiss[1]); end
    end
    wr(17'h00040, 64'h0123_4567_89AB_CDEF);
    look(1, 19'h00100);
    tick();
    checks++; if (o_isHit[1] !== 1'b1) begin errors++; $display("FAIL sticky_refill_hit: got %b expected 1", o_isHit[1]); end
    checks++; if (o_isMiss[1] !== 1'b0) begin errors++; $display("FAIL sticky_refill_miss: got %b expected 0", o_isMiss[1]); end
    idle();
    tick();
    checks++; if (o_isMiss[1] !== 1'b0) begin errors++; $display("FAIL sticky_cleared: got %b expected 0", o_isMiss[1]); end
  endtask

  task automatic test_eviction();
    do_reset();
    wr(17'h00010, 64'hA3A3_A2A2_A1A1_A0A0);
    tick();
    wr(17'h00020, 64'hB3B3_B2B2_B1B1_B0B0);
    tick();
    idle();
    look(0, 19'h00040);
    tick();
    checks++; if (o_isHit[0] !== 1'b1 || o_dataOut[15:0] !== 16'hA0A0) begin errors++; $display("FAIL evict_a: hit %b data %h expected 1 A0A0", o_isHit[0], o_dataOut[15:0]); end
    look(0, 19'h00080);
    tick();
    checks++; if (o_isHit[0] !== 1'b1 || o_dataOut[15:0] !== 16'hB0B0) begin errors++; $display("FAIL evict_b: hit %b data %h expected 1 B0B0", o_isHit[0], o_dataOut[15:0]); end
    look(0, 19'h00040);
    tick();
    checks++; if (o_isHit[0] !== 1'b1) begin errors++; $display("FAIL evict_mru: got %b expected 1", o_isHit[0]); end
    idle();
    tick();
    wr(17'h00040, 64'hC3C3_C2C2_C1C1_C0C0);
    tick();
    idle();
    look(0, 19'h00040);
    look(1, 19'h00080);
    tick();
    checks++; if (o_isHit[0] !== 1'b1 || o_dataOut[15:0] !== 16'hA0A0) begin errors++; $display("FAIL evict_keep_a: hit %b data %h expected 1 A0A0", o_isHit[0], o_dataOut[15:0]); end
    checks++; if (o_isHit[1] !== 1'b0 || o_isMiss[1] !== 1'b1) begin errors++; $display("FAIL evict_lost_b: hit %b miss %b expected 0 1", o_isHit[1], o_isMiss[1]); end
    idle();
    look(0, 19'h00100);
    tick();
    checks++; if (o_isHit[0] !== 1'b1 || o_dataOut[15:0] !== 16'hC0C0) begin errors++; $display("FAIL evict_new_c: hit %b data %h expected 1 C0C0", o_isHit[0], o_dataOut[15:0]); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr(17'h00020, 64'hDDDD_CCCC_BBBB_5A5A);
    look(0, 19'h00080);
    look(1, 19'h00080);
    tick();
    checks++; if (o_isHit !== 2'b11) begin errors++; $display("FAIL same_hit: got %b expected 11", o_isHit); end
    checks++; if (o_isMiss !== 2'b00) begin errors++; $display("FAIL same_miss: got %b expected 00", o_isMiss); end
    checks++; if (o_dataOut !== 32'h5A5A_5A5A) begin errors++; $display("FAIL same_data: got %h expected 5a5a5a5a", o_dataOut); end
    idle();
  endtask

  task automatic test_clear_and_reset();
    wr(17'h00010, 64'h1111_1111_1111_1111);
    tick();
    wr(17'h00030, 64'h3333_3333_3333_3333);
    i_clearCache = 1'b1;
    tick();
    idle();
    look(0, 19'h00040);
    look(1, 19'h00080);
    tick();
    checks++; if (o_isHit !== 2'b00) begin errors++; $display("FAIL clear_hit: got %b expected 00", o_isHit); end
    checks++; if (o_isMiss !== 2'b11) begin errors++; $display("FAIL clear_miss: got %b expected 11", o_isMiss); end
    idle();
    look(0, 19'h000C0);
    tick();
    checks++; if (o_isHit[0] !== 1'b0 || o_isMiss[0] !== 1'b1) begin errors++; $display("FAIL clear_dropped_write: hit %b miss %b expected 0 1", o_isHit[0], o_isMiss[0]); end
    i_rst = 1'b1;
    model_reset();
    #1;
    checks++; if (o_isHit !== 2'b00 || o_isMiss !== 2'b00) begin errors++; $display("FAIL midreset_out: hit %b miss %b expected 00 00", o_isHit, o_isMiss); end
    idle();
    tick();
    i_rst = 1'b0;
    tick();
    checks++; if (o_isMiss !== 2'b00) begin errors++; $display("FAIL midreset_sticky: got %b expected 00", o_isMiss); end
  endtask

  task automatic test_tc0_swizzle();
    i_textureFormatTrueColor = 1'b0;
    do_reset();
    wr(17'h01234, 64'hFEED_0C0C_0B0B_0A0A);
    look(0, 19'h048D3);
    look(1, 19'h048D0);
    tick();
    checks++; if (o_isHit !== 2'b11) begin errors++; $display("FAIL tc0_hit: got %b expected 11", o_isHit); end
    checks++; if (o_dataOut[15:0] !== 16'hFEED) begin errors++; $display("FAIL tc0_texel3: got %h expected feed", o_dataOut[15:0]); end
    checks++; if (o_dataOut[31:16] !== 16'h0A0A) begin errors++; $display("FAIL tc0_texel0: got %h expected 0a0a", o_dataOut[31:16]); end
    idle();
  endtask

  function automatic logic [16:0] pool_addr();
    return 17'(($urandom_range(0, 7) << 3) | $urandom_range(0, 1));
  endfunction

  task automatic test_random(input logic tc);
    logic [16:0] w;
    logic [16:0] s;
    bit ok;
    i_textureFormatTrueColor = tc;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      i_clearCache = ($urandom_range(0, 59) == 0);
      i_write = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        w = pool_addr();
        s = swz(w, tc);
        ok = 1'b1;
        // Keep writes off sets whose LRU a displayed hit updates at the same edge.
        for (int p = 0; p < NP; p++)
          if (e_req[p] && e_hit[p] && e_set[p] == int'(s) % NS) ok = 1'b0;
        if (ok) wr(w, {$urandom, $urandom});
      end
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) look(p, {pool_addr(), 2'($urandom_range(0, 3))});
        else i_requLookup[p] = 1'b0;
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        logic exp_h, exp_m;
        exp_h = e_req[p] & e_hit[p];
        exp_m = !e_hit[p] & (e_req[p] | m_sticky[p]);
        checks++; if (o_isHit[p] !== exp_h) begin errors++; $display("FAIL rand_hit tc%0d cyc%0d port%0d: got %b expected %b", tc, c, p, o_isHit[p], exp_h); end
        checks++; if (o_isMiss[p] !== exp_m) begin errors++; $display("FAIL rand_miss tc%0d cyc%0d port%0d: got %b expected %b", tc, c, p, o_isMiss[p], exp_m); end
        if (exp_h) begin
          checks++; if (o_dataOut[16*p +: 16] !== e_dat[p]) begin errors++; $display("FAIL rand_data tc%0d cyc%0d port%0d: got %h expected %h", tc, c, p, o_dataOut[16*p +: 16], e_dat[p]); end
        end
      end
    end
    idle();
  endtask

  initial begin
    i_rst = 1'b0;
    i_clearCache = 1'b0;
    i_textureFormatTrueColor = 1'b1;
    i_write = 1'b0;
    i_adressIn = '0;
    i_dataIn = '0;
    i_requLookup = '0;
    i_adressLook = '0;
    test_reset();
    test_basic_hit();
    test_sticky_miss();
    test_eviction();
    test_same_cycle();
    test_clear_and_reset();
    test_tc0_swizzle();
    test_random(1'b1);
    test_random(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
